// File: rtl/ram_burst_arbiter.sv
// rtl/ram_burst_arbiter.sv - round-robin burst arbiter for the shared single-port image RAM
// One whole burst is granted at a time. The RAM executes on negedge, and read data returns one cycle later.
module ram_burst_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 8,
    parameter int MEM_DEPTH = 32768
) (
    input  logic                clk,
    input  logic                RST,
    input  logic [1:0]          req_i,
    input  logic [1:0]          we_i,
    input  logic [2*ADDR_W-1:0] addr_i,
    input  logic [2*LEN_W-1:0]  len_i,
    input  logic [2*DATA_W-1:0] wdata_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          wnext_o,
    output logic [1:0]          rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          done_o,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_read_signal,
    output logic                ram_write_signal,
    input  logic [DATA_W-1:0]   ram_dataout
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic              win;
    logic              last;
    logic              we_l;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len_l;
    logic [LEN_W-1:0]  cnt;

    logic              pick;
    logic [1:0]        pick_oh;
    logic [1:0]        win_oh;
    logic [ADDR_W-1:0] addr_sel;
    logic [LEN_W-1:0]  len_sel;
    logic [ADDR_W-1:0] next_addr;

    // When both ports request, the one not served last wins the tie.
    always_comb begin
        pick      = (req_i == 2'b11) ? ~last : req_i[1];
        pick_oh   = pick ? 2'b10 : 2'b01;
        win_oh    = win ? 2'b10 : 2'b01;
        addr_sel  = pick ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
        len_sel   = pick ? len_i[2*LEN_W-1:LEN_W] : len_i[LEN_W-1:0];
        next_addr = (base + ADDR_W'(cnt) + ADDR_W'(1)) & ADDR_MASK;
    end

    // The requester presents the current word, and it advances after each wnext pulse.
    assign ram_data = ram_write_signal ?
                      (win ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0]) : '0;

    always_ff @(posedge clk) begin
        if (RST) begin
            state            <= IDLE;
            win              <= 1'b0;
            last             <= 1'b1;
            we_l             <= 1'b0;
            base             <= '0;
            len_l            <= '0;
            cnt              <= '0;
            gnt_o            <= '0;
            wnext_o          <= '0;
            rvalid_o         <= '0;
            rdata_o          <= '0;
            done_o           <= '0;
            ram_address      <= '0;
            ram_read_signal  <= 1'b0;
            ram_write_signal <= 1'b0;
        end else begin
            done_o   <= '0;
            rvalid_o <= '0;
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        win              <= pick;
                        we_l             <= we_i[pick];
                        base             <= addr_sel;
                        len_l            <= len_sel;
                        cnt              <= '0;
                        ram_address      <= addr_sel & ADDR_MASK;
                        ram_write_signal <= we_i[pick];
                        ram_read_signal  <= ~we_i[pick];
                        gnt_o            <= pick_oh;
                        wnext_o          <= we_i[pick] ? pick_oh : 2'b00;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The RAM read data for this cycle is valid at its closing edge.
                    if (!we_l) begin
                        rvalid_o <= win_oh;
                        rdata_o  <= ram_dataout;
                    end
                    if (cnt == len_l) begin
                        ram_read_signal  <= 1'b0;
                        ram_write_signal <= 1'b0;
                        wnext_o          <= '0;
                        done_o           <= win_oh;
                        state            <= DONE;
                    end else begin
                        cnt         <= cnt + LEN_W'(1);
                        ram_address <= next_addr;
                    end
                end
                DONE: begin
                    gnt_o <= '0;
                    last  <= win;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
